rr_arb2_stage: RTL and testbench

Registered two-input round-robin arbiter that sits directly upstream of the 2:1 bit-select mux. It accepts words from two valid/ready producers and computes the 1-bit select. It drives the selected word and its select bit out through a single output register. Downstream logic uses `out_sel` as the mux select and `out_data` as the granted payload. The arbiter guarantees fair alternation under contention and holds output stable under back-pressure.

---
 rtl/arb_pkg.sv | 15 +
 rtl/rr_arb2_stage_if.sv | 32 +++
 rtl/rr_grant2.sv | 22 ++
 rtl/rr_arb2_stage.sv | 78 +++++++
 tb/tb_rr_arb2_stage.sv | 135 +++++++++++++
 5 files changed

// File: rtl/arb_pkg.sv
// Shared definitions for the two-input round-robin arbiter stage:
// select encodings, output-register state encoding and default payload width.
package arb_pkg;

    localparam logic SEL_IN0 = 1'b0;
    localparam logic SEL_IN1 = 1'b1;

    localparam int ARB_DW = 8;

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } state_t;

endpackage

// File: rtl/rr_arb2_stage_if.sv
// Handshake bundle for rr_arb2_stage: two valid/ready producers in, one
// registered valid/ready word (with its select bit) out.
interface rr_arb2_stage_if
    import arb_pkg::*;
#(
    parameter int DW = ARB_DW
);
    logic          in0_valid;
    logic [DW-1:0] in0_data;
    logic          in0_ready;
    logic          in1_valid;
    logic [DW-1:0] in1_data;
    logic          in1_ready;
    logic          out_valid;
    logic [DW-1:0] out_data;
    logic          out_sel;
    logic          out_ready;

    // Producer/consumer side.
    modport master (
        output in0_valid, in0_data, input in0_ready,
        output in1_valid, in1_data, input in1_ready,
        input  out_valid, out_data, out_sel, output out_ready
    );

    // Arbiter side.
    modport slave (
        input  in0_valid, in0_data, output in0_ready,
        input  in1_valid, in1_data, output in1_ready,
        output out_valid, out_data, out_sel, input out_ready
    );
endinterface

// File: rtl/rr_grant2.sv
// Combinational two-way round-robin grant: a lone requester always wins,
// a tie goes to the input named by prio.
module rr_grant2
    import arb_pkg::*;
(
    input  logic v0,
    input  logic v1,
    input  logic prio,
    output logic gnt_valid,
    output logic gnt
);
    always_comb begin
        gnt_valid = v0 | v1;
        if (v0 && v1) begin
            gnt = prio;
        end else if (v1) begin
            gnt = SEL_IN1;
        end else begin
            gnt = SEL_IN0;
        end
    end
endmodule

// File: rtl/rr_arb2_stage.sv
// Registered 2-input round-robin arbiter: grants one producer per cycle into a
// single output register that carries the payload and its select bit.
module rr_arb2_stage
    import arb_pkg::*;
#(
    parameter int DW = ARB_DW
) (
    input  logic            clk,
    input  logic            rst_n,
    rr_arb2_stage_if.slave  bus
);
    state_t        state_reg, state_next;
    logic [DW-1:0] data_reg, data_next;
    logic          sel_reg, sel_next;
    logic          prio_reg, prio_next;

    logic          load;
    logic          gnt_valid;
    logic          gnt;
    logic [1:0]    in_ready;

    rr_grant2 u_grant (
        .v0        (bus.in0_valid),
        .v1        (bus.in1_valid),
        .prio      (prio_reg),
        .gnt_valid (gnt_valid),
        .gnt       (gnt)
    );

    // The register can take a word when empty or when its word drains this cycle.
    assign load = (state_reg == ST_EMPTY) || bus.out_ready;

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_ready
            assign in_ready[gi] = load && gnt_valid && (gnt == 1'(gi));
        end
    endgenerate

    assign bus.in0_ready = in_ready[0];
    assign bus.in1_ready = in_ready[1];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg <= ST_EMPTY;
            data_reg  <= '0;
            sel_reg   <= SEL_IN0;
            prio_reg  <= SEL_IN0;
        end else begin
            state_reg <= state_next;
            data_reg  <= data_next;
            sel_reg   <= sel_next;
            prio_reg  <= prio_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        data_next  = data_reg;
        sel_next   = sel_reg;
        prio_next  = prio_reg;
        if (load) begin
            if (gnt_valid) begin
                state_next = ST_FULL;
                data_next  = (gnt == SEL_IN1) ? bus.in1_data : bus.in0_data;
                sel_next   = gnt;
                // Winner yields the tie-break so a waiting competitor goes next.
                prio_next  = ~gnt;
            end else begin
                state_next = ST_EMPTY;
            end
        end
    end

    assign bus.out_valid = (state_reg == ST_FULL);
    assign bus.out_data  = data_reg;
    assign bus.out_sel   = sel_reg;
endmodule

// File: tb/tb_rr_arb2_stage.sv
// Directed table-driven bench for rr_arb2_stage plus short hand-written
// sequences for combinational ready behaviour around a full register.
module tb_rr_arb2_stage;
    localparam int DW = 8;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    rr_arb2_stage_if #(.DW(DW)) bus ();

    rr_arb2_stage #(.DW(DW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic          rst_n;
        logic          v0;
        logic [DW-1:0] d0;
        logic          v1;
        logic [DW-1:0] d1;
        logic          ordy;
        logic          chk_rdy;
        logic          er0;
        logic          er1;
        logic          ev;
        logic          chk_data;
        logic [DW-1:0] ed;
        logic          es;
    } vec_t;

    vec_t vecs[21];
    int   n_vec = 0;
    int   n_err = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic r, input logic v0, input logic [DW-1:0] d0,
                         input logic v1, input logic [DW-1:0] d1, input logic ordy);
        rst_n         = r;
        bus.in0_valid = v0;
        bus.in0_data  = d0;
        bus.in1_valid = v1;
        bus.in1_data  = d1;
        bus.out_ready = ordy;
    endtask

    task automatic edge_settle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // rst  v0 d0     v1 d1     ordy chk er0 er1 ev  cd  ed     es
        vecs[0]  = '{0, 1, 8'hA5, 1, 8'h3C, 1, 0, 0, 0, 0, 1, 8'h00, 0};
        vecs[1]  = '{0, 1, 8'hA5, 1, 8'h3C, 1, 0, 0, 0, 0, 1, 8'h00, 0};
        vecs[2]  = '{1, 1, 8'hA5, 1, 8'h3C, 1, 1, 1, 0, 1, 1, 8'hA5, 0};
        vecs[3]  = '{1, 1, 8'hA5, 1, 8'h3C, 1, 1, 0, 1, 1, 1, 8'h3C, 1};
        vecs[4]  = '{1, 1, 8'hA5, 1, 8'h3C, 1, 1, 1, 0, 1, 1, 8'hA5, 0};
        vecs[5]  = '{1, 1, 8'hA5, 1, 8'h3C, 1, 1, 0, 1, 1, 1, 8'h3C, 1};
        vecs[6]  = '{1, 0, 8'h00, 1, 8'h11, 1, 1, 0, 1, 1, 1, 8'h11, 1};
        vecs[7]  = '{1, 0, 8'h00, 1, 8'h22, 1, 1, 0, 1, 1, 1, 8'h22, 1};
        vecs[8]  = '{1, 0, 8'h00, 1, 8'h33, 1, 1, 0, 1, 1, 1, 8'h33, 1};
        vecs[9]  = '{1, 1, 8'h5A, 0, 8'h00, 1, 1, 1, 0, 1, 1, 8'h5A, 0};
        vecs[10] = '{1, 1, 8'hA5, 1, 8'h3C, 0, 1, 0, 0, 1, 1, 8'h5A, 0};
        vecs[11] = '{1, 1, 8'hA5, 1, 8'h3C, 0, 1, 0, 0, 1, 1, 8'h5A, 0};
        vecs[12] = '{1, 1, 8'hA5, 1, 8'h3C, 0, 1, 0, 0, 1, 1, 8'h5A, 0};
        vecs[13] = '{1, 1, 8'hA5, 1, 8'h3C, 1, 1, 0, 1, 1, 1, 8'h3C, 1};
        vecs[14] = '{1, 1, 8'h77, 0, 8'h00, 1, 1, 1, 0, 1, 1, 8'h77, 0};
        vecs[15] = '{1, 1, 8'h88, 0, 8'h00, 1, 1, 1, 0, 1, 1, 8'h88, 0};
        vecs[16] = '{1, 0, 8'h00, 0, 8'h00, 1, 1, 0, 0, 0, 0, 8'h00, 0};
        vecs[17] = '{1, 1, 8'hA5, 1, 8'h3C, 1, 1, 0, 1, 1, 1, 8'h3C, 1};
        vecs[18] = '{1, 1, 8'h99, 0, 8'h00, 1, 1, 1, 0, 1, 1, 8'h99, 0};
        vecs[19] = '{0, 1, 8'h99, 0, 8'h00, 1, 0, 0, 0, 0, 1, 8'h00, 0};
        vecs[20] = '{1, 1, 8'hA5, 1, 8'h3C, 1, 1, 1, 0, 1, 1, 8'hA5, 0};

        drive(0, 0, '0, 0, '0, 0);
        #1;

        for (int i = 0; i < 21; i++) begin
            drive(vecs[i].rst_n, vecs[i].v0, vecs[i].d0, vecs[i].v1, vecs[i].d1, vecs[i].ordy);
            #2;
            if (vecs[i].chk_rdy) begin
                chk($sformatf("v%0d in0_ready", i), 32'(bus.in0_ready), 32'(vecs[i].er0));
                chk($sformatf("v%0d in1_ready", i), 32'(bus.in1_ready), 32'(vecs[i].er1));
            end
            edge_settle();
            chk($sformatf("v%0d out_valid", i), 32'(bus.out_valid), 32'(vecs[i].ev));
            if (vecs[i].chk_data) begin
                chk($sformatf("v%0d out_data", i), 32'(bus.out_data), 32'(vecs[i].ed));
                chk($sformatf("v%0d out_sel", i), 32'(bus.out_sel), 32'(vecs[i].es));
            end
        end

        // Reset, then a lone in1 word loads into the empty register.
        drive(0, 0, '0, 0, '0, 0);
        edge_settle();
        chk("seq reset out_valid", 32'(bus.out_valid), 32'd0);
        drive(1, 0, '0, 1, 8'hC3, 0);
        #2;
        chk("seq empty in1_ready", 32'(bus.in1_ready), 32'd1);
        chk("seq empty in0_ready", 32'(bus.in0_ready), 32'd0);
        edge_settle();
        chk("seq load out_data", 32'(bus.out_data), 32'hC3);
        chk("seq load out_sel", 32'(bus.out_sel), 32'd1);

        // Full register: in1_ready follows out_ready with no clock edge.
        drive(1, 0, '0, 1, 8'hD4, 0);
        #2;
        chk("seq full stall in1_ready", 32'(bus.in1_ready), 32'd0);
        bus.out_ready = 1'b1;
        #2;
        chk("seq full drain in1_ready", 32'(bus.in1_ready), 32'd1);
        edge_settle();
        chk("seq refill out_valid", 32'(bus.out_valid), 32'd1);
        chk("seq refill out_data", 32'(bus.out_data), 32'hD4);

        // No producer while draining empties the register.
        drive(1, 0, '0, 0, '0, 1);
        edge_settle();
        chk("seq drain out_valid", 32'(bus.out_valid), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
